rr_grant_sequencer: RTL and testbench

Round-robin arbiter that shares one 8-way decoded resource among eight requesters. It scans pending requests starting after the last winner and registers the winner's 3-bit index. It drives a one-hot grant vector, which is the 3-to-8 decode of that index. It also bounds how long any single requester can hold the resource. It sits in front of the binary decoder datapath and owns all sequencing of which output line is active.

---
 rtl/rr_grant_sequencer.sv | 77 +++++++
 tb/tb_rr_grant_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rr_grant_sequencer.sv
// rtl/rr_grant_sequencer.sv - round-robin arbiter with one-hot grant and bounded hold time
module rr_grant_sequencer #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       preempt
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        r_state;
  logic [2:0]    r_ptr;
  logic [CW-1:0] r_cnt;

  logic [15:0] w_dbl;
  logic [7:0]  w_rot;
  logic [2:0]  w_off;
  logic [2:0]  w_win;

  // Rotate req so bit 0 is the search start; lowest set bit is the winner offset.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[r_ptr +: 8];

  always_comb begin
    w_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) w_off = 3'(i);
    end
    w_win = r_ptr + w_off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= 3'd0;
      r_cnt       <= '0;
      grant       <= 8'h00;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            grant_idx   <= w_win;
            grant       <= 8'd1 << w_win;
            grant_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (!req[grant_idx] || (r_cnt == CNT_LAST)) begin
            grant       <= 8'h00;
            grant_valid <= 1'b0;
            r_ptr       <= grant_idx + 3'd1;
            preempt     <= req[grant_idx];
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// tb/tb_rr_grant_sequencer.sv - scoreboard bench for rr_grant_sequencer (MAX_HOLD 16 and 4)
module tb_rr_grant_sequencer;

  typedef struct {
    int         sel;
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
    logic       p;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] req16, req4;
  logic [7:0] g16, g4;
  logic [2:0] i16, i4;
  logic       v16, v4, p16, p4;

  exp_t exp_q[$];
  exp_t e;
  event chk_ev;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;
  logic [7:0] ag;
  logic [2:0] ai;
  logic       av, ap;
  logic [2:0] ix;

  rr_grant_sequencer #(.MAX_HOLD(16)) u_dut16 (
    .clk(clk), .rst(rst), .req(req16),
    .grant(g16), .grant_idx(i16), .grant_valid(v16), .preempt(p16)
  );

  rr_grant_sequencer #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4),
    .grant(g4), .grant_idx(i4), .grant_valid(v4), .preempt(p4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    if (!done) begin
      n_fail++;
      $display("FAIL watchdog: wait expired before test sequence completed");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    forever begin
      @(negedge clk or chk_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.sel == 16) begin
          ag = g16; ai = i16; av = v16; ap = p16;
        end else begin
          ag = g4; ai = i4; av = v4; ap = p4;
        end
        n_tests++;
        if (ag !== e.g || ai !== e.i || av !== e.v || ap !== e.p) begin
          n_fail++;
          $display("FAIL %s: got grant=%h idx=%0d valid=%b preempt=%b, want grant=%h idx=%0d valid=%b preempt=%b",
                   e.tag, ag, ai, av, ap, e.g, e.i, e.v, e.p);
        end
      end
    end
  end

  task automatic step(input int sel, input logic [7:0] r, input logic [7:0] eg,
                      input logic [2:0] ei, input logic ev, input logic ep, input string tag);
    if (sel == 16) begin
      req16 = r; req4 = 8'h00;
    end else begin
      req4 = r; req16 = 8'h00;
    end
    @(posedge clk);
    #1;
    exp_q.push_back('{sel, eg, ei, ev, ep, tag});
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    req16 = 8'h00;
    req4  = 8'h00;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    req16 = 8'h00;
    req4  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (g16 !== 8'h00 || i16 !== 3'd0 || v16 !== 1'b0 || p16 !== 1'b0 ||
        g4  !== 8'h00 || i4  !== 3'd0 || v4  !== 1'b0 || p4  !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: dut16 grant=%h idx=%0d valid=%b preempt=%b, dut4 grant=%h idx=%0d valid=%b preempt=%b",
               g16, i16, v16, p16, g4, i4, v4, p4);
    end
    rst = 1'b0;

    for (int k = 0; k < 5; k++) step(16, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "idle16");
    step(4, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "idle4");

    step(16, 8'h84, 8'h04, 3'd2, 1'b1, 1'b0, "wrap_g2");
    step(16, 8'h84, 8'h04, 3'd2, 1'b1, 1'b0, "wrap_g2_hold");
    step(16, 8'h80, 8'h00, 3'd2, 1'b0, 1'b0, "wrap_rel2");
    step(16, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0, "wrap_g7");
    step(16, 8'h04, 8'h00, 3'd7, 1'b0, 1'b0, "wrap_rel7");
    step(16, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0, "wrap_g2_again");
    step(16, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0, "wrap_rel_final");
    step(16, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0, "wrap_idle");

    do_reset();
    for (int k = 0; k < 9; k++) begin
      ix = 3'(k % 8);
      step(16, 8'hFF, 8'd1 << ix, ix, 1'b1, 1'b0, $sformatf("rr_g%0d_c1", k));
      step(16, 8'hFF, 8'd1 << ix, ix, 1'b1, 1'b0, $sformatf("rr_g%0d_c2", k));
      step(16, 8'hFF, 8'd1 << ix, ix, 1'b1, 1'b0, $sformatf("rr_g%0d_c3", k));
      step(16, 8'hFF & ~(8'd1 << ix), 8'h00, ix, 1'b0, 1'b0, $sformatf("rr_gap%0d", k));
    end
    step(16, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "rr_idle");

    for (int k = 0; k < 4; k++) step(4, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0, "solo_hold");
    step(4, 8'h20, 8'h00, 3'd5, 1'b0, 1'b1, "solo_preempt");
    step(4, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0, "solo_regrant");
    step(4, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0, "solo_rel");
    step(4, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0, "solo_idle");

    for (int k = 0; k < 4; k++) step(4, 8'h0A, 8'h02, 3'd1, 1'b1, 1'b0, "pair_hold1");
    step(4, 8'h0A, 8'h00, 3'd1, 1'b0, 1'b1, "pair_pre1");
    for (int k = 0; k < 4; k++) step(4, 8'h0A, 8'h08, 3'd3, 1'b1, 1'b0, "pair_hold3");
    step(4, 8'h0A, 8'h00, 3'd3, 1'b0, 1'b1, "pair_pre3");
    step(4, 8'h0A, 8'h02, 3'd1, 1'b1, 1'b0, "pair_back1");
    step(4, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, "pair_rel");
    step(4, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, "pair_idle");

    do_reset();
    step(16, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0, "arst_g4");
    step(16, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0, "arst_g4_hold");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_q.push_back('{16, 8'h00, 3'd0, 1'b0, 1'b0, "arst_immediate"});
    -> chk_ev;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(16, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0, "arst_regrant");
    step(16, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0, "arst_rel");

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
